// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Bundles the PS/2 keyboard lines and the decoded-key outputs that the
// decoder hands to the tone player.
//   PS2_CLK, PS2_DATA : keyboard clock/data, asynchronous, idle high
//   hex1, hex0        : high/low nibble of the held make code
//   keyup             : high while the held key is down
//   kbstrobe_o        : one-cycle pulse on each accepted new press
//   ext               : held code carried an E0 prefix
//   err_o             : one-cycle pulse on parity/stop/timeout error
// master = decoder side, slave = keyboard/player side.
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [3:0] hex1;
    logic [3:0] hex0;
    logic       keyup;
    logic       kbstrobe_o;
    logic       ext;
    logic       err_o;

    modport master (
        input  PS2_CLK, PS2_DATA,
        output hex1, hex0, keyup, kbstrobe_o, ext, err_o
    );

    modport slave (
        output PS2_CLK, PS2_DATA,
        input  hex1, hex0, keyup, kbstrobe_o, ext, err_o
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Receives PS/2 keyboard frames (start, 8 data LSB first, odd parity, stop),
// decodes make/break scan codes with E0/F0 prefixes and presents the held key
// to the MP3 tone player.
// Ports:
//   CLK  : system clock (100 MHz)
//   rst  : synchronous, active-high reset
//   kb   : ps2_key_decoder_if.master (PS/2 lines in, decoded key out)
// Parameters:
//   FILT        : equal consecutive samples needed to move the filtered clock
//   TIMEOUT_CYC : CLK cycles without a sample event before a frame is aborted
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int FILT        = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              CLK,
    input  logic              rst,
    ps2_key_decoder_if.master kb
);

    localparam int FW = $clog2(FILT + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ---- stage p0: two-flop synchronisers ---------------------------------
    logic ps2_clk_p0, ps2_clk_p1;
    logic ps2_data_p0, ps2_data_p1;

    always_ff @(posedge CLK) begin
        if (rst) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= kb.PS2_CLK;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= kb.PS2_DATA;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // ---- stage p1: clock glitch filter and falling-edge sample event ------
    logic          clk_filt_p1;
    logic [FW-1:0] filt_cnt;
    logic          fall_p1;

    // The filtered level only moves once FILT samples in a row disagree with
    // it; any agreeing sample restarts the run, so short glitches vanish.
    always_ff @(posedge CLK) begin
        if (rst) begin
            clk_filt_p1 <= 1'b1;
            filt_cnt    <= '0;
            fall_p1     <= 1'b0;
        end else begin
            fall_p1 <= 1'b0;
            if (ps2_clk_p1 == clk_filt_p1) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt_p1 <= ps2_clk_p1;
                filt_cnt    <= '0;
                fall_p1     <= ~ps2_clk_p1;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // ---- frame FSM ----------------------------------------------------------
    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_bit, par_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          byte_ok;
    logic          frame_err;
    logic          tmo_err;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        shreg   <= shreg_nxt;
        par_bit <= par_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par_bit;
        tmo_nxt     = '0;
        byte_ok     = 1'b0;
        frame_err   = 1'b0;
        tmo_err     = 1'b0;

        case (state)
            IDLE: begin
                if (fall_p1 && !ps2_data_p1) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (fall_p1) begin
                    shreg_nxt   = {ps2_data_p1, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (fall_p1) begin
                    par_nxt   = ps2_data_p1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (fall_p1) begin
                    // Odd parity: data plus parity bit holds an odd number of 1s.
                    if (ps2_data_p1 && (^{shreg, par_bit}))
                        byte_ok = 1'b1;
                    else
                        frame_err = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Watchdog for a keyboard that stops clocking mid-frame.
        if (state != IDLE && !fall_p1) begin
            if (tmo_cnt == TMO_LAST) begin
                state_nxt = IDLE;
                tmo_err   = 1'b1;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
            end
        end
    end

    // ---- stage p2: scan-code interpretation and registered outputs --------
    logic [7:0] code_p2;
    logic       ext_p2;
    logic       keyup_p2;
    logic       strobe_p2;
    logic       err_p2;
    logic       e0_pend;
    logic       f0_pend;
    logic       key_match;
    logic       bat_ack;

    assign key_match = (shreg == code_p2) && (e0_pend == ext_p2);
    assign bat_ack   = (shreg == 8'hAA) || (shreg == 8'hFA);

    always_ff @(posedge CLK) begin
        if (rst) begin
            code_p2   <= '0;
            ext_p2    <= 1'b0;
            keyup_p2  <= 1'b0;
            strobe_p2 <= 1'b0;
            err_p2    <= 1'b0;
            e0_pend   <= 1'b0;
            f0_pend   <= 1'b0;
        end else begin
            strobe_p2 <= 1'b0;
            err_p2    <= frame_err | tmo_err;
            if (frame_err) begin
                e0_pend <= 1'b0;
                f0_pend <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    e0_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    f0_pend <= 1'b1;
                end else begin
                    e0_pend <= 1'b0;
                    f0_pend <= 1'b0;
                    if (f0_pend) begin
                        // Break: only releases the key actually being held.
                        if (key_match) keyup_p2 <= 1'b0;
                    end else if (bat_ack && e0_pend) begin
                        // E0-prefixed AA/FA is not a key press; drop it.
                    end else if (!(keyup_p2 && key_match)) begin
                        // New press (a held key's auto-repeat is swallowed).
                        code_p2   <= shreg;
                        ext_p2    <= e0_pend;
                        keyup_p2  <= 1'b1;
                        strobe_p2 <= 1'b1;
                    end
                end
            end
        end
    end

    assign kb.hex1       = code_p2[7:4];
    assign kb.hex0       = code_p2[3:0];
    assign kb.keyup      = keyup_p2;
    assign kb.kbstrobe_o = strobe_p2;
    assign kb.ext        = ext_p2;
    assign kb.err_o      = err_p2;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the MP3 tone player. Receives PS/2 keyboard frames and decodes make/break scan codes.
- Presents the held key to the player as hex1/hex0 plus keyup, and issues kbstrobe on each new press.
- Runs in the system CLK domain (100 MHz); PS/2 lines are asynchronous inputs.

Parameters:
- FILT, 8: consecutive identical samples required before the filtered PS2_CLK level changes.
- TIMEOUT_CYC, 200000: CLK cycles without a falling edge mid-frame before the frame is aborted (2 ms).

Ports:
- CLK  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  keyboard clock, asynchronous, idle high.
- PS2_DATA  in  1  keyboard data, asynchronous, idle high.
- hex1  out  4  high nibble of the held make code.
- hex0  out  4  low nibble of the held make code.
- keyup  out  1  high while the key in hex1/hex0 is held down.
- kbstrobe_o  out  1  one-cycle pulse when a new key press is accepted.
- ext  out  1  held code carried an E0 prefix.
- err_o  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset: hex1=0, hex0=0, keyup=0, kbstrobe_o=0, ext=0, err_o=0. State=IDLE, prefix flags cleared, synchronisers and filter set to 1. Reset wins over all other events, including mid-frame.
- Input path: 2-FF synchroniser on each PS/2 line. The filtered clock level changes only after FILT equal consecutive samples. A falling edge of the filtered clock is a 1-cycle sample event, and PS2_DATA (synchronised) is sampled on that event.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a sample of 0 (start bit) goes to DATA with bit count 0. A sample of 1 stays in IDLE.
  - DATA: shifts in 8 bits, LSB first, into shreg[7:0]. After the 8th bit, go to PARITY.
  - PARITY: stores the sampled bit, then goes to STOP.
  - STOP: a sample of 1 with odd parity over data+parity makes the byte valid. A bad stop bit or bad parity pulses err_o, discards the byte and clears both prefix flags. Either way, return to IDLE.
- Timeout: in any non-IDLE state, a counter increments each cycle and clears on each sample event. At TIMEOUT_CYC the frame is aborted: go to IDLE, pulse err_o once, leave outputs unchanged.
- Valid-byte handling, in the cycle after STOP:
  - E0: set e0_pend. No output change.
  - F0: set f0_pend. No output change.
  - Any other byte with f0_pend=1 (break): if byte==held code and e0_pend==ext, keyup<=0; otherwise ignore. hex1/hex0/ext are retained. Clear both flags.
  - Any other byte with f0_pend=0 (make):
    - If keyup=1, byte==held code and e0_pend==ext: typematic repeat, no change and no strobe.
    - Otherwise: hex1<=byte[7:4], hex0<=byte[3:0], ext<=e0_pend, keyup<=1, kbstrobe_o=1 for exactly one cycle coincident with the update.
    - Clear both flags.
- A new make while another key is held replaces the held key (last-pressed wins) and strobes.
- Latency: outputs update exactly 1 CLK after the STOP sample event.
- kbstrobe_o and err_o never assert in the same cycle.
- Bytes AA (BAT) and FA (ACK) are treated as make codes only if received without a prefix. The player ignores unmapped codes.

Test Plan:
- Make: frame 0x1C (bits 0,00111000,parity 0,stop 1) at a 12.5 kHz PS/2 clock -> hex1=1, hex0=C, keyup=1, kbstrobe_o high for exactly 1 CLK, 1 cycle after the STOP edge.
- Typematic and break: three more 0x1C frames -> no further strobe, keyup stays 1. Then F0, 1C -> keyup=0, hex1/hex0 stay 1/C, no strobe.
- Key change and mismatched break: make 1C, then make 1B -> strobe, hex0=B. Then F0,1C -> keyup stays 1. Then F0,1B -> keyup=0.
- Errors: 0x23 frame with even parity -> err_o one pulse, outputs unchanged. Then 0x23 frame with stop=0 -> err_o pulse. Then stop PS2_CLK after 4 data bits for 2.1 ms -> err_o pulse and the next good 0x23 frame decodes to hex1=2, hex0=3.
- Glitch and extended: 3-cycle low glitches on PS2_CLK between edges -> no extra bits, 0x1D decodes correctly. Then E0, 1D -> ext=1 and strobe. Then F0, 1D (no E0) -> keyup stays 1.
- Reset mid-frame: assert rst for 1 CLK after 5 data bits -> all outputs 0 next cycle. Remaining bits are ignored until a fresh start bit, and the next full 0x1C frame decodes normally.
